// File: rtl/mem_fill_pkg.sv
// ============================================================================
//  mem_fill_pkg
//  Shared state encoding and fill-mode constants for mem_fill_engine.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package mem_fill_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_t;

    localparam logic MODE_CONST = 1'b0;
    localparam logic MODE_INC   = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mem_fill_engine.sv
// ============================================================================
//  mem_fill_engine
//  Writes a programmable, wrapping address range of a single-port RAM with a
//  constant or incrementing pattern, honouring ram_ready stalls and abort.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module mem_fill_engine
    import mem_fill_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] count_m1,
    input  logic [DATA_W-1:0] fill_value,
    input  logic              ram_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              busy,
    output logic              done
);

    fill_state_t       r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_rem;
    logic [DATA_W-1:0] r_data;
    logic              r_mode;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_rem   <= '0;
            r_data  <= '0;
            r_mode  <= MODE_CONST;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_addr  <= base_addr;
                        r_rem   <= count_m1;
                        r_data  <= fill_value;
                        r_mode  <= mode;
                        r_state <= FILL;
                    end
                end
                FILL: begin
                    // Abort wins over ram_ready: the word on the bus this cycle is dropped.
                    if (abort) begin
                        r_state <= IDLE;
                    end else if (ram_ready) begin
                        if (r_rem == '0) begin
                            r_state <= DONE;
                        end else begin
                            r_addr <= r_addr + ADDR_W'(1);
                            r_rem  <= r_rem - ADDR_W'(1);
                            if (r_mode == MODE_INC) begin
                                r_data <= r_data + DATA_W'(1);
                            end
                        end
                    end
                end
                DONE: begin
                    if (!start) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Strobes depend on the state register only, so no input reaches an output combinationally.
    assign ram_we   = (r_state == FILL);
    assign busy     = (r_state == FILL);
    assign done     = (r_state == DONE);
    assign ram_addr = r_addr;
    assign ram_data = r_data;

endmodule

`default_nettype wire

// File: tb/tb_mem_fill_engine.sv
// ============================================================================
//  tb_mem_fill_engine
//  Randomised self-checking bench for mem_fill_engine against an arithmetic model.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_fill_engine;

    localparam int AW    = 6;
    localparam int DW    = 2;
    localparam int DEPTH = 1 << AW;
    localparam int DMOD  = 1 << DW;
    localparam int MAXC  = 400;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          mode;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] count_m1;
    logic [DW-1:0] fill_value;
    logic          ram_ready;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;
    int hold_err;
    int busy_err;
    logic [AW-1:0] obs_a[$];
    logic [DW-1:0] obs_d[$];

    mem_fill_engine #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
        .base_addr(base_addr), .count_m1(count_m1), .fill_value(fill_value),
        .ram_ready(ram_ready), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_data(ram_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Reference: word i of a fill goes to (base+i) mod depth with value v or (v+i) mod 2**DW.
    function automatic int first_diff(input logic [AW-1:0] b, input int n_exp,
                                      input logic md, input logic [DW-1:0] v);
        for (int i = 0; i < obs_a.size() && i < n_exp; i++) begin
            int ea;
            int ed;
            ea = (int'(b) + i) % DEPTH;
            ed = md ? (int'(v) + i) % DMOD : int'(v);
            if (int'(obs_a[i]) != ea || int'(obs_d[i]) != ed) return i;
        end
        return -1;
    endfunction

    // Runs one fill, recording every accepted write; leaves start high (engine in DONE).
    task automatic do_fill(input logic [AW-1:0] b, input logic [AW-1:0] cm1,
                           input logic md, input logic [DW-1:0] v,
                           input int stall_pct, input int stall_word, input int stall_len,
                           input logic abort_first,
                           output int done_cyc, output int first_we, output int stalls);
        logic          hold;
        logic [AW-1:0] ha;
        logic [DW-1:0] hd;
        int            st_cnt;
        obs_a.delete();
        obs_d.delete();
        hold_err = 0; busy_err = 0; done_cyc = -1; first_we = -1; stalls = 0;
        hold = 1'b0; st_cnt = 0; ha = '0; hd = '0;
        @(negedge clk);
        base_addr = b; count_m1 = cm1; mode = md; fill_value = v;
        start = 1'b1; abort = abort_first; ram_ready = 1'b0;
        for (int c = 1; c <= MAXC; c++) begin
            @(negedge clk);
            abort = 1'b0;
            base_addr = AW'($urandom); count_m1 = AW'($urandom);
            mode = 1'($urandom); fill_value = DW'($urandom);
            if (busy !== ram_we) busy_err++;
            if (hold && (ram_we !== 1'b1 || ram_addr !== ha || ram_data !== hd)) hold_err++;
            hold = 1'b0;
            if (done === 1'b1) begin
                done_cyc = c;
                break;
            end
            ram_ready = 1'b0;
            if (ram_we === 1'b1) begin
                if (first_we < 0) first_we = c;
                if (obs_a.size() == stall_word && st_cnt < stall_len) begin
                    st_cnt++;
                end else begin
                    ram_ready = ($urandom_range(99) >= stall_pct);
                end
                if (ram_ready) begin
                    obs_a.push_back(ram_addr);
                    obs_d.push_back(ram_data);
                end else begin
                    stalls++;
                    hold = 1'b1; ha = ram_addr; hd = ram_data;
                end
            end
        end
        ram_ready = 1'b0;
    endtask

    task automatic release_start();
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0; ram_ready = 1'b0;
        base_addr = '0; count_m1 = '0; fill_value = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ram_we, busy, done, ram_addr, ram_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got we=%b busy=%b done=%b addr=%0d data=%0d want all 0",
                     ram_we, busy, done, ram_addr, ram_data);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (ram_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got we=%b want 0", ram_we);
        end
    endtask

    task automatic test_full_clear();
        int dc, fw, st, d;
        do_fill(6'd0, 6'd63, 1'b0, 2'd0, 0, -1, 0, 1'b0, dc, fw, st);
        d = first_diff(6'd0, 64, 1'b0, 2'd0);
        checks++;
        if (obs_a.size() != 64 || d != -1) begin
            errors++;
            $display("FAIL clear_writes got n=%0d diff_at=%0d want n=64 diff_at=-1", obs_a.size(), d);
        end
        checks++;
        if (fw != 1 || dc != 65) begin
            errors++;
            $display("FAIL clear_timing got first_we=%0d done_cyc=%0d want 1 65", fw, dc);
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL clear_done_hold got %b want 1", done);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL clear_done_drop got done=%b we=%b want 0 0", done, ram_we);
        end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        int dc, fw, st, d;
        // abort alongside start in IDLE must be ignored
        do_fill(6'd62, 6'd3, 1'b1, 2'b11, 0, -1, 0, 1'b1, dc, fw, st);
        d = first_diff(6'd62, 4, 1'b1, 2'b11);
        checks++;
        if (obs_a.size() != 4 || d != -1 || dc != 5) begin
            errors++;
            $display("FAIL wrap_writes got n=%0d diff_at=%0d done_cyc=%0d want 4 -1 5",
                     obs_a.size(), d, dc);
        end
        release_start();
    endtask

    task automatic test_stall();
        int dc, fw, st, d;
        do_fill(6'd10, 6'd2, 1'b1, 2'd1, 0, 1, 3, 1'b0, dc, fw, st);
        d = first_diff(6'd10, 3, 1'b1, 2'd1);
        checks++;
        if (obs_a.size() != 3 || d != -1) begin
            errors++;
            $display("FAIL stall_writes got n=%0d diff_at=%0d want 3 -1", obs_a.size(), d);
        end
        checks++;
        if (hold_err != 0 || busy_err != 0 || st != 3 || dc != 7) begin
            errors++;
            $display("FAIL stall_hold got hold_err=%0d busy_err=%0d stalls=%0d done_cyc=%0d want 0 0 3 7",
                     hold_err, busy_err, st, dc);
        end
        release_start();
    endtask

    task automatic test_abort();
        int k, dc, fw, st, d, bad;
        logic [AW-1:0] nb;
        logic [DW-1:0] v;
        v = DW'($urandom);
        obs_a.delete(); obs_d.delete();
        k = 0;
        @(negedge clk);
        base_addr = 6'd0; count_m1 = 6'd63; mode = 1'b0; fill_value = v;
        start = 1'b1; ram_ready = 1'b1;
        for (int c = 0; c < MAXC; c++) begin
            @(negedge clk);
            if (ram_we === 1'b1) begin
                k++;
                if (k == 5) begin
                    abort = 1'b1; start = 1'b0;
                    break;
                end
                obs_a.push_back(ram_addr);
                obs_d.push_back(ram_data);
            end
        end
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (k != 5 || ram_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_stop got k=%0d we=%b busy=%b done=%b want 5 0 0 0", k, ram_we, busy, done);
        end
        d = first_diff(6'd0, 4, 1'b0, v);
        checks++;
        if (obs_a.size() != 4 || d != -1) begin
            errors++;
            $display("FAIL abort_prefix got n=%0d diff_at=%0d want 4 -1", obs_a.size(), d);
        end
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (ram_we !== 1'b0 || done !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL abort_idle got %0d active cycles want 0", bad);
        end
        nb = AW'($urandom);
        do_fill(nb, 6'd5, 1'b1, 2'd2, 0, -1, 0, 1'b0, dc, fw, st);
        d = first_diff(nb, 6, 1'b1, 2'd2);
        checks++;
        if (obs_a.size() != 6 || d != -1 || dc != 7) begin
            errors++;
            $display("FAIL abort_refill got n=%0d diff_at=%0d done_cyc=%0d want 6 -1 7", obs_a.size(), d, dc);
        end
        release_start();
    endtask

    task automatic test_reset_mid_fill();
        int k, bad;
        k = 0;
        @(negedge clk);
        base_addr = AW'($urandom); count_m1 = 6'd63; mode = 1'b1; fill_value = DW'($urandom);
        start = 1'b1; ram_ready = 1'b1;
        for (int c = 0; c < MAXC; c++) begin
            @(negedge clk);
            if (ram_we === 1'b1) k++;
            if (k == 20) break;
        end
        start = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (k != 20 || {ram_we, busy, done, ram_addr, ram_data} !== '0) begin
            errors++;
            $display("FAIL reset_async got k=%0d we=%b busy=%b done=%b addr=%0d data=%0d want 20 and all 0",
                     k, ram_we, busy, done, ram_addr, ram_data);
        end
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (ram_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_no_write got %0d active cycles want 0", bad);
        end
    endtask

    task automatic test_start_held();
        int dc, fw, st, d, bad;
        do_fill(6'd40, 6'd2, 1'b0, 2'd3, 0, -1, 0, 1'b0, dc, fw, st);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (done !== 1'b1 || ram_we !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (dc != 4 || bad != 0) begin
            errors++;
            $display("FAIL held_done got done_cyc=%0d bad_cycles=%0d want 4 0", dc, bad);
        end
        @(negedge clk);
        start = 1'b0;
        do_fill(6'd7, 6'd1, 1'b1, 2'd0, 0, -1, 0, 1'b0, dc, fw, st);
        d = first_diff(6'd7, 2, 1'b1, 2'd0);
        checks++;
        if (obs_a.size() != 2 || d != -1 || fw != 1) begin
            errors++;
            $display("FAIL held_restart got n=%0d diff_at=%0d first_we=%0d want 2 -1 1", obs_a.size(), d, fw);
        end
        release_start();
    endtask

    task automatic test_random();
        int dc, fw, st, d, n;
        logic [AW-1:0] b, cm1;
        logic          md;
        logic [DW-1:0] v;
        for (int t = 0; t < 8; t++) begin
            b = AW'($urandom); cm1 = AW'($urandom); md = 1'($urandom); v = DW'($urandom);
            n = int'(cm1) + 1;
            do_fill(b, cm1, md, v, 30, -1, 0, 1'b0, dc, fw, st);
            d = first_diff(b, n, md, v);
            checks++;
            if (obs_a.size() != n || d != -1) begin
                errors++;
                $display("FAIL rand_writes[%0d] got n=%0d diff_at=%0d want %0d -1", t, obs_a.size(), d, n);
            end
            checks++;
            if (dc != n + st + 1 || hold_err != 0 || busy_err != 0) begin
                errors++;
                $display("FAIL rand_timing[%0d] got done_cyc=%0d hold_err=%0d busy_err=%0d want %0d 0 0",
                         t, dc, hold_err, busy_err, n + st + 1);
            end
            release_start();
        end
    endtask

    initial begin
        test_reset();
        test_full_clear();
        test_wrap();
        test_stall();
        test_abort();
        test_reset_mid_fill();
        test_start_held();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
